ex_unit: RTL
============

# ex_unit

Execute stage of the five-stage MIPS pipeline. It consumes the decoded operation bundle produced by instruction decode (ALU opcode, two 32-bit operands, write-enable, destination register) and computes the result. It also owns the HI/LO register pair and an iterative 32-cycle divider. While the divider runs it raises a stall request, and it registers the write-back bundle toward the memory stage.

## Interface
Parameters:
- DATA_W, 32, operand/result width; fixed at 32, no other value supported.
- DIV_CYCLES, 32, divider iteration count; must equal DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- aluop_i  input  8  decoded ALU opcode.
- reg1_i  input  32  operand 1; rs value, or shamt in [4:0] for shifts.
- reg2_i  input  32  operand 2; rt value or zero-extended immediate.
- wreg_i  input  1  destination write enable from decode.
- wd_i  input  5  destination register index.
- flush_i  input  1  pipeline flush; aborts divider, suppresses write-back.
- wdata_o  output  32  registered result.
- wd_o  output  5  registered destination index.
- wreg_o  output  1  registered write enable.
- stallreq_o  output  1  combinational; 1 = hold upstream stages and inputs.
- hi_o  output  32  current HI register.
- lo_o  output  32  current LO register.

## Operation
Opcodes (aluop_i):
- Logic: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
- Shifts: SLL 0x7C, SRL 0x02, SRA 0x03; result = reg2_i shifted by reg1_i[4:0].
- Arithmetic: ADD/ADDU 0x20/0x21, SUB 0x22, SLT 0x2A (signed), SLTU 0x2B (unsigned); wrap modulo 2^32, no overflow trap.
- MULT 0x18: signed 64-bit product in a single cycle; {HI,LO} written at the clock edge; wreg_o=0.
- DIV 0x1A / DIVU 0x1B: LO=quotient, HI=remainder; wreg_o=0.
  - Signed: divide magnitudes; quotient negated if operand signs differ; remainder takes the dividend's sign.
- MFHI 0x10 / MFLO 0x12: wdata_o=HI/LO; wreg_o=wreg_i.
- Any other opcode: wdata_o=0, wreg_o=0, HI/LO unchanged.
- For ALU ops: wreg_o=wreg_i, wd_o=wd_i.

Divider FSM:
- IDLE: a DIV/DIVU present → load operand magnitudes, counter=0, assert stallreq_o → BUSY.
- BUSY: one restoring shift-subtract step per cycle; stallreq_o=1; counter increments. After DIV_CYCLES steps → DONE.
- DONE: stallreq_o=0; sign fix applied; HI/LO written at this edge; wreg_o=0 issued → IDLE.
- Divide by zero: skips BUSY (IDLE→DONE next cycle, one stall cycle); LO=0xFFFFFFFF, HI=dividend (raw reg1_i).
- flush_i in any state: → IDLE next edge, HI/LO unchanged, wreg_o=0, stallreq_o=0 in that cycle.

## Timing
- Reset values: wdata_o=0, wd_o=0, wreg_o=0, hi_o=0, lo_o=0, stallreq_o=0, FSM=IDLE, counter=0.
- Reset mid-divide: FSM returns to IDLE, and all of the values above apply at the next edge.
- Non-divide ops: 1-cycle latency; inputs in cycle N → outputs valid in cycle N+1.
- Divide (nonzero divisor): stallreq_o high in cycles N..N+32 (33 cycles); DONE in cycle N+33; HI/LO visible in cycle N+34.
- Upstream holds aluop_i, reg1_i and reg2_i stable while stallreq_o=1.
  - Operands are latched at acceptance, so later input changes do not corrupt the divide.
- During stall cycles: wreg_o=0, so no bubble write-back occurs.
- MFHI/MFLO in the cycle after MULT or DONE returns the new value; no forwarding is required because HI/LO are registered.
- MULT and divide-DONE never coincide, since the stall blocks issue.

## Configuration
- Macro: EX_UNIT_DIV_EN.
- Defined: divider FSM compiled in, with behaviour as above.
- Undefined: FSM omitted.
  - DIV/DIVU act as unknown opcodes: wdata_o=0, wreg_o=0, HI/LO unchanged.
  - stallreq_o is tied to 0.

## Test plan
- Reset, then OR reg1=0x0000F0F0, reg2=0x00000F0F, wreg=1, wd=5 → next cycle wdata_o=0x0000FFFF, wd_o=5, wreg_o=1.
- SRA reg1=4, reg2=0x80000000 → wdata_o=0xF8000000; SLT reg1=0xFFFFFFFF, reg2=1 → wdata_o=1; SLTU with the same operands → wdata_o=0.
- MULT reg1=0xFFFFFFFE (-2), reg2=3, then MFLO and MFHI.
  - Required: wreg_o=0 for MULT; MFLO returns 0xFFFFFFFA; MFHI returns 0xFFFFFFFF.
- DIV reg1=-7 (0xFFFFFFF9), reg2=2.
  - Required: stallreq_o high for exactly 33 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1).
  - Required: DIVU 100/7 gives LO=14, HI=2.
- DIV in progress, flush_i pulsed at iteration 10 → stallreq_o drops in that cycle, HI/LO retain prior values, FSM IDLE.
  - Repeat the same scenario with rst instead of flush_i → all outputs 0.
- DIV with divisor 0, dividend 0x1234 → one stall cycle, then LO=0xFFFFFFFF, HI=0x1234.
  - Required without EX_UNIT_DIV_EN: no stall, HI/LO unchanged.

Source files
------------

// File: rtl/ex_unit.sv
// ex_unit: execute stage of the five-stage MIPS pipeline.
// Computes logic/shift/arithmetic results, owns the HI/LO pair, performs a
// single-cycle signed MULT and (optionally) an iterative restoring divider.
// Optional feature macro: EX_UNIT_DIV_EN compiles in the DIV/DIVU state
// machine; without it DIV/DIVU behave as unknown opcodes and no stall occurs.
module ex_unit #(
   parameter int DATA_W     = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        aluop_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] reg2_i,
   input  logic              wreg_i,
   input  logic [4:0]        wd_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic              stallreq_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_OR   = 8'h25;
   localparam logic [7:0] OP_XOR  = 8'h26;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ADD  = 8'h20;
   localparam logic [7:0] OP_ADDU = 8'h21;
   localparam logic [7:0] OP_SUB  = 8'h22;
   localparam logic [7:0] OP_SLT  = 8'h2A;
   localparam logic [7:0] OP_SLTU = 8'h2B;
   localparam logic [7:0] OP_MULT = 8'h18;
   localparam logic [7:0] OP_MFHI = 8'h10;
   localparam logic [7:0] OP_MFLO = 8'h12;

   // Registered write-back bundle and HI/LO pair
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [4:0]        wd_q, wd_d;
   logic              wreg_q, wreg_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   logic [DATA_W-1:0]   alu_res;
   logic                alu_wr;
   logic [2*DATA_W-1:0] mult_prod;
   logic                issue_ok;
   logic                div_done;

   // Sign-extending both operands to 64 bits makes the low 64 bits of the
   // unsigned product equal to the signed product.
   assign mult_prod = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} *
                      {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};

   // Single-cycle ALU result and whether the opcode produces a register write
   always_comb begin
      alu_res = '0;
      alu_wr  = 1'b1;
      case (aluop_i)
         OP_AND:  alu_res = reg1_i & reg2_i;
         OP_OR:   alu_res = reg1_i | reg2_i;
         OP_XOR:  alu_res = reg1_i ^ reg2_i;
         OP_NOR:  alu_res = ~(reg1_i | reg2_i);
         OP_SLL:  alu_res = reg2_i << reg1_i[4:0];
         OP_SRL:  alu_res = reg2_i >> reg1_i[4:0];
         OP_SRA:  alu_res = $signed(reg2_i) >>> reg1_i[4:0];
         OP_ADD,
         OP_ADDU: alu_res = reg1_i + reg2_i;
         OP_SUB:  alu_res = reg1_i - reg2_i;
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
         OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
         OP_MFHI: alu_res = hi_q;
         OP_MFLO: alu_res = lo_q;
         default: alu_wr  = 1'b0;
      endcase
   end

`ifdef EX_UNIT_DIV_EN
   localparam int CNT_W = $clog2(DIV_CYCLES) + 1;
   localparam logic [7:0] OP_DIV  = 8'h1A;
   localparam logic [7:0] OP_DIVU = 8'h1B;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_t;

   div_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;

   logic              is_div;
   logic              div_signed;
   logic [DATA_W-1:0] dvd_mag;
   logic [DATA_W-1:0] dvs_mag;
   logic [DATA_W:0]   rem_shift;
   logic [DATA_W:0]   rem_diff;
   logic [DATA_W-1:0] quo_fix;
   logic [DATA_W-1:0] rem_fix;

   // Divider datapath: operand magnitudes, one restoring step, final sign fix
   always_comb begin
      is_div     = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
      div_signed = (aluop_i == OP_DIV);
      dvd_mag    = (div_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
      dvs_mag    = (div_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
      rem_shift  = {rem_q, quo_q[DATA_W-1]};
      rem_diff   = rem_shift - {1'b0, dvs_q};
      quo_fix    = qneg_q ? -quo_q : quo_q;
      rem_fix    = rneg_q ? -rem_q : rem_q;
   end

   // Divider state machine: accept in IDLE, iterate in BUSY, retire in DONE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      unique case (state_q)
         DIV_IDLE: begin
            if (is_div) begin
               cnt_d = '0;
               if (reg2_i == '0) begin
                  quo_d   = '1;
                  rem_d   = reg1_i;
                  dvs_d   = '0;
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = DIV_DONE;
               end else begin
                  quo_d   = dvd_mag;
                  rem_d   = '0;
                  dvs_d   = dvs_mag;
                  qneg_d  = div_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                  rneg_d  = div_signed && reg1_i[DATA_W-1];
                  state_d = DIV_BUSY;
               end
            end
         end
         DIV_BUSY: begin
            if (rem_diff[DATA_W]) begin
               rem_d = rem_shift[DATA_W-1:0];
               quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end else begin
               rem_d = rem_diff[DATA_W-1:0];
               quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
      if (flush_i) begin
         state_d = DIV_IDLE;
      end
   end

   assign stallreq_o = !rst && !flush_i &&
                       (((state_q == DIV_IDLE) && is_div) || (state_q == DIV_BUSY));
   assign issue_ok   = (state_q == DIV_IDLE);
   assign div_done   = (state_q == DIV_DONE);
`else
   assign stallreq_o = 1'b0;
   assign issue_ok   = 1'b1;
   assign div_done   = 1'b0;
`endif

   // Next write-back bundle and HI/LO; a flush suppresses every write
   always_comb begin
      wd_d    = wd_i;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (!flush_i) begin
         if (issue_ok) begin
            wdata_d = alu_res;
            wreg_d  = wreg_i && alu_wr;
            if (aluop_i == OP_MULT) begin
               hi_d = mult_prod[2*DATA_W-1:DATA_W];
               lo_d = mult_prod[DATA_W-1:0];
            end
         end
`ifdef EX_UNIT_DIV_EN
         if (div_done) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
         end
`endif
      end
   end

   // All state registers, synchronously cleared by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         wdata_q <= '0;
         wd_q    <= '0;
         wreg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef EX_UNIT_DIV_EN
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         wdata_q <= wdata_d;
         wd_q    <= wd_d;
         wreg_q  <= wreg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef EX_UNIT_DIV_EN
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign wdata_o = wdata_q;
   assign wd_o    = wd_q;
   assign wreg_o  = wreg_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule
